// File: rtl/hsv_core_commit_reorder.sv
// -----------------------------------------------------------------------------
// hsv_core_commit_reorder
//
// In-order commit buffer. Execution units deliver results tagged with an
// instruction token in any order; entries are parked in a slot chosen by the
// low token bits and released to the commit stage strictly in token order,
// starting from token 0 after reset or flush.
//
// Ports
//   clk_core    core clock
//   rst_core_n  asynchronous active-low reset (same effect as flush)
//   flush       synchronous clear of all state, head token returns to 0
//   in_valid    per-unit result valid                     [NumUnits]
//   in_ready    per-unit accept                           [NumUnits]
//   in_token    per-unit token, unit i at [i*TokenWidth +: TokenWidth]
//   in_data     per-unit payload, unit i at [i*DataWidth +: DataWidth]
//   out_valid   head entry present
//   out_ready   commit stage accepts the head
//   out_token   token of the head entry (the head counter)
//   out_data    payload of the head entry
//   occupancy   number of filled slots (0..Depth)
// -----------------------------------------------------------------------------
package hsv_core_commit_reorder_pkg;

  // Payload carried from execute to commit; opaque to the reorder buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd_value;
    logic [4:0]  rd_addr;
    logic        rd_write;
    logic        trap;
  } commit_data_t;

endpackage

module hsv_core_commit_reorder
  import hsv_core_commit_reorder_pkg::*;
#(
  parameter int NumUnits   = 4,
  parameter int Depth      = 16,
  parameter int TokenWidth = 8,
  parameter int DataWidth  = $bits(commit_data_t)
) (
  input  logic                             clk_core,
  input  logic                             rst_core_n,
  input  logic                             flush,
  input  logic [NumUnits-1:0]              in_valid,
  output logic [NumUnits-1:0]              in_ready,
  input  logic [NumUnits*TokenWidth-1:0]   in_token,
  input  logic [NumUnits*DataWidth-1:0]    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TokenWidth-1:0]            out_token,
  output logic [DataWidth-1:0]             out_data,
  output logic [$clog2(Depth+1)-1:0]       occupancy
);

  localparam int SlotW = $clog2(Depth);
  localparam int OccW  = $clog2(Depth + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [Depth-1:0]      r_valid;
  logic [DataWidth-1:0]  r_data [Depth];
  logic [TokenWidth-1:0] r_head;
  logic [OccW-1:0]       r_occ;

  // ---------------------------------------------------------------------------
  // Per-unit decode: slot index and window membership
  // ---------------------------------------------------------------------------
  logic [TokenWidth-1:0] w_token     [NumUnits];
  logic [TokenWidth-1:0] w_dist      [NumUnits];
  logic [SlotW-1:0]      w_slot      [NumUnits];
  logic [NumUnits-1:0]   w_in_window;
  logic [NumUnits-1:0]   w_ready;
  logic [NumUnits-1:0]   w_accept;
  logic [SlotW-1:0]      w_head_slot;
  logic                  w_pop;
  logic [OccW-1:0]       w_acc_cnt;
  logic [Depth-1:0]      w_valid_next;

  assign w_head_slot = r_head[SlotW-1:0];

  // NOTE: every signal written in an always_comb gets a default assignment
  // before any conditional update, so no path leaves it holding a value and
  // no latch is inferred.
  always_comb begin
    w_in_window = '0;
    for (int i = 0; i < NumUnits; i++) begin
      w_token[i] = in_token[i*TokenWidth +: TokenWidth];
      w_slot[i]  = w_token[i][SlotW-1:0];
      // Modulo distance from the head; the extra bit keeps the compare
      // correct when Depth equals the full token space.
      w_dist[i]  = w_token[i] - r_head;
      w_in_window[i] = ({1'b0, w_dist[i]} < (TokenWidth + 1)'(Depth));
    end
  end

  // Ready uses only registered state, this unit's token and the valids of
  // lower-index units (which win a shared slot); never its own valid.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NumUnits; i++) begin
      w_ready[i] = w_in_window[i] && !r_valid[w_slot[i]] && !flush;
      for (int j = 0; j < i; j++) begin
        if (in_valid[j] && (w_slot[j] == w_slot[i])) begin
          w_ready[i] = 1'b0;
        end
      end
    end
  end

  assign in_ready = w_ready;
  assign w_accept = in_valid & w_ready;

  // ---------------------------------------------------------------------------
  // Head / commit side
  // ---------------------------------------------------------------------------
  assign out_valid = r_valid[w_head_slot];
  assign out_data  = r_data[w_head_slot];
  assign out_token = r_head;
  assign occupancy = r_occ;

  assign w_pop = out_valid && out_ready && !flush;

  // A pop only hits a full slot and an accept only an empty one, so the
  // clear and the sets below never target the same bit in one cycle.
  always_comb begin
    w_valid_next = r_valid;
    w_acc_cnt    = '0;
    if (w_pop) begin
      w_valid_next[w_head_slot] = 1'b0;
    end
    for (int i = 0; i < NumUnits; i++) begin
      if (w_accept[i]) begin
        w_valid_next[w_slot[i]] = 1'b1;
        w_acc_cnt               = w_acc_cnt + OccW'(1);
      end
    end
  end

  // NOTE: clocked state is updated only with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_occ   <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_head  <= r_head + TokenWidth'(w_pop);
      r_occ   <= r_occ + w_acc_cnt - OccW'(w_pop);
    end
  end

  // NOTE: payload storage has no reset; a slot's data is only observed while
  // its valid bit is set, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_core) begin
    for (int i = 0; i < NumUnits; i++) begin
      if (w_accept[i]) begin
        r_data[w_slot[i]] <= in_data[i*DataWidth +: DataWidth];
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_commit_reorder.sv
// -----------------------------------------------------------------------------
// Testbench for hsv_core_commit_reorder (NumUnits=4, Depth=16, TokenWidth=8).
// Directed stimulus pushes the expected commit sequence into a queue; a
// monitor on the falling edge pops and compares whenever a commit handshake
// is presented. Cycle-level state (occupancy, ready, head) is checked inline.
// -----------------------------------------------------------------------------
module tb_hsv_core_commit_reorder;
  import hsv_core_commit_reorder_pkg::*;

  localparam int NU    = 4;
  localparam int DEPTH = 16;
  localparam int TW    = 8;
  localparam int DW    = $bits(commit_data_t);
  localparam int OW    = $clog2(DEPTH + 1);

  logic               clk_core = 1'b0;
  logic               rst_core_n;
  logic               flush;
  logic [NU-1:0]      in_valid;
  logic [NU-1:0]      in_ready;
  logic [NU*TW-1:0]   in_token;
  logic [NU*DW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [TW-1:0]      out_token;
  logic [DW-1:0]      out_data;
  logic [OW-1:0]      occupancy;

  hsv_core_commit_reorder #(
    .NumUnits  (NU),
    .Depth     (DEPTH),
    .TokenWidth(TW),
    .DataWidth (DW)
  ) dut (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_token  (in_token),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_token (out_token),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [TW-1:0] token;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Payload derived from the full (unwrapped) token number and a per-test salt.
  function automatic logic [DW-1:0] mk_data(int tok, int salt);
    logic [DW-1:0] d;
    d          = '0;
    d[7:0]     = tok[7:0];
    d[15:8]    = salt[7:0];
    d[24:16]   = tok[8:0] ^ 9'h15a;
    d[DW-1 -: 8] = ~tok[7:0];
    return d;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_commit(int tok, int salt);
    exp_t e;
    e.token = tok[TW-1:0];
    e.data  = mk_data(tok, salt);
    exp_q.push_back(e);
  endtask

  task automatic set_unit(int u, bit v, int tok, int salt);
    in_valid[u]          = v;
    in_token[u*TW +: TW] = tok[TW-1:0];
    in_data[u*DW +: DW]  = mk_data(tok, salt);
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_occ", occupancy, 0);
    check("flush_head", out_token, 0);
  endtask

  // Commit monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk_core) begin
    if (rst_core_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_commit: actual token %0d required no commit", out_token);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_token", out_token, mon_e.token);
        check("commit_data", out_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_core_n = 1'b0;
    flush      = 1'b0;
    in_valid   = '0;
    in_token   = '0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk_core);
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_token", out_token, 0);
    rst_core_n = 1'b1;
    tick();

    // ---- In-order stream on unit 0 ----
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) expect_commit(k, 1);
    for (int k = 0; k < 3; k++) begin
      set_unit(0, 1'b1, k, 1);
      #1 check("inorder_ready", in_ready[0], 1);
      tick();
      check("inorder_occ", occupancy, 1);
      check("inorder_head", out_token, k);
      check("inorder_valid", out_valid, 1);
    end
    set_unit(0, 1'b0, 0, 0);
    tick();
    check("inorder_drain_occ", occupancy, 0);
    check("inorder_drain_valid", out_valid, 0);
    out_ready = 1'b0;
    do_flush();

    // ---- Out-of-order arrival: 2, 1, then 0 ----
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) expect_commit(k, 2);
    set_unit(2, 1'b1, 2, 2);
    tick();
    set_unit(2, 1'b0, 0, 0);
    set_unit(1, 1'b1, 1, 2);
    #1 check("ooo_hole1_valid", out_valid, 0);
    tick();
    set_unit(1, 1'b0, 0, 0);
    set_unit(0, 1'b1, 0, 2);
    #1 check("ooo_hole2_valid", out_valid, 0);
    check("ooo_occ2", occupancy, 2);
    tick();
    set_unit(0, 1'b0, 0, 0);
    check("ooo_peak_occ", occupancy, 3);
    check("ooo_head0_valid", out_valid, 1);
    check("ooo_head0_token", out_token, 0);
    tick();
    check("ooo_occ_after1", occupancy, 2);
    check("ooo_head1_token", out_token, 1);
    tick();
    check("ooo_occ_after2", occupancy, 1);
    check("ooo_head2_token", out_token, 2);
    tick();
    check("ooo_empty_occ", occupancy, 0);
    check("ooo_empty_valid", out_valid, 0);
    out_ready = 1'b0;
    do_flush();

    // ---- Backpressure until full, then single pop and slot reuse ----
    for (int k = 0; k <= 16; k++) expect_commit(k, 3);
    for (int c = 0; c < 4; c++) begin
      for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 4 * c + u, 3);
      tick();
    end
    for (int u = 0; u < NU; u++) set_unit(u, 1'b0, 0, 0);
    check("full_occ", occupancy, 16);
    set_unit(0, 1'b1, 16, 3);
    #1 check("full_ready_tok16", in_ready[0], 0);
    check("full_head_valid", out_valid, 1);
    check("full_head_token", out_token, 0);
    tick();
    check("full_stall_occ", occupancy, 16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_after_pop_occ", occupancy, 15);
    check("full_reuse_ready", in_ready[0], 1);
    tick();
    set_unit(0, 1'b0, 0, 0);
    check("full_refill_occ", occupancy, 16);
    out_ready = 1'b1;
    repeat (16) tick();
    out_ready = 1'b0;
    check("full_drain_occ", occupancy, 0);
    do_flush();

    // ---- Same-slot conflict between units 1 and 3 ----
    for (int k = 0; k < 6; k++) expect_commit(k, 4);
    set_unit(1, 1'b0, 5, 4);
    set_unit(3, 1'b1, 5, 4);
    #1 check("conf_idle_ready1", in_ready[1], 1);
    check("conf_idle_ready3", in_ready[3], 1);
    set_unit(1, 1'b1, 5, 4);
    #1 check("conf_ready1", in_ready[1], 1);
    check("conf_ready3", in_ready[3], 0);
    tick();
    set_unit(1, 1'b0, 0, 0);
    set_unit(3, 1'b1, 21, 4);
    #1 check("conf_held_ready3", in_ready[3], 0);
    check("conf_occ", occupancy, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_unit(0, 1'b1, k, 4);
      tick();
    end
    set_unit(0, 1'b0, 0, 0);
    #1 check("conf_wait_ready3_a", in_ready[3], 0);
    tick();
    check("conf_head5_token", out_token, 5);
    check("conf_head5_valid", out_valid, 1);
    check("conf_wait_ready3_b", in_ready[3], 0);
    tick();
    check("conf_slot_free_ready3", in_ready[3], 1);
    tick();
    set_unit(3, 1'b0, 0, 0);
    out_ready = 1'b0;
    check("conf_accept_occ", occupancy, 1);
    check("conf_hole_valid", out_valid, 0);
    check("conf_hole_token", out_token, 6);
    do_flush();

    // ---- Token wrap-around: 300 back-to-back tokens ----
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      expect_commit(k, 5);
      set_unit(0, 1'b1, k, 5);
      #1 check("wrap_ready", in_ready[0], 1);
      tick();
    end
    set_unit(0, 1'b0, 0, 0);
    tick();
    check("wrap_occ", occupancy, 0);
    out_ready = 1'b0;
    do_flush();

    // ---- Flush with pending entries, pop and accept requested ----
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, u, 6);
    tick();
    for (int u = 1; u < NU; u++) set_unit(u, 1'b0, 0, 0);
    set_unit(0, 1'b1, 4, 6);
    tick();
    check("preflush_occ", occupancy, 5);
    flush     = 1'b1;
    out_ready = 1'b1;
    set_unit(0, 1'b1, 5, 6);
    #1 check("flush_cycle_ready", in_ready[0], 0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    set_unit(0, 1'b0, 0, 0);
    check("postflush_occ", occupancy, 0);
    check("postflush_valid", out_valid, 0);
    check("postflush_token", out_token, 0);

    // ---- Asynchronous reset mid-cycle with a non-zero head ----
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, u, 7);
    tick();
    for (int u = 1; u < NU; u++) set_unit(u, 1'b0, 0, 0);
    set_unit(0, 1'b1, 4, 7);
    tick();
    set_unit(0, 1'b0, 0, 0);
    expect_commit(0, 7);
    expect_commit(1, 7);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("prerst_head", out_token, 2);
    check("prerst_occ", occupancy, 3);
    #2 rst_core_n = 1'b0;
    #1 check("asyncrst_occ", occupancy, 0);
    check("asyncrst_valid", out_valid, 0);
    check("asyncrst_token", out_token, 0);
    #2 rst_core_n = 1'b1;
    tick();
    check("postrst_occ", occupancy, 0);
    check("postrst_valid", out_valid, 0);

    // Post-reset sanity: token 0 flows straight through.
    expect_commit(0, 8);
    out_ready = 1'b1;
    set_unit(0, 1'b1, 0, 8);
    #1 check("postrst_ready", in_ready[0], 1);
    tick();
    set_unit(0, 1'b0, 0, 0);
    tick();
    out_ready = 1'b0;
    check("postrst_final_occ", occupancy, 0);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
